// File: rtl/horner_x_ramp_source.sv
// -----------------------------------------------------------------------------
// horner_x_ramp_source
//   Stimulus source for the cubic Horner pipeline. A start pulse in IDLE launches
//   one frame of NUM_SAMPLES abscissae x_k = X0 + k*STEP. Each x_k goes out as an
//   IEEE-754 double on an AXI-Stream master port, and TLAST marks the final beat.
//   The source honours backpressure fully. Every output comes from a register.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : asynchronous, active-high reset
//   start       : frame request, sampled only in IDLE
//   nexti       : downstream TREADY
//   nexto       : TVALID / TDATA[63:0] / TLAST toward the first Horner stage
//   busy        : high while a frame is in flight (SEND)
//   done        : one-cycle pulse after the last beat's handshake
//   sample_idx  : index k of the beat currently presented, 0 outside SEND
// -----------------------------------------------------------------------------
package axi_stream_pkg;
  typedef struct packed {
    logic tready;
  } axi_stream_masteri_slaveo_t;

  typedef struct packed {
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
  } axi_stream_mastero_slavei_t;
endpackage

module horner_x_ramp_source
  import axi_stream_pkg::*;
#(
  parameter real X0          = 0.0,
  parameter real STEP        = 1.0,
  parameter int  NUM_SAMPLES = 8,
  parameter int  CW          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  axi_stream_masteri_slaveo_t nexti,
  output axi_stream_mastero_slavei_t nexto,
  output logic                       busy,
  output logic                       done,
  output logic [CW-1:0]              sample_idx
);

  if (NUM_SAMPLES < 1 || longint'(NUM_SAMPLES) >= (longint'(1) << CW)) begin : g_bad_num_samples
    $error("horner_x_ramp_source: NUM_SAMPLES must be >= 1 and < 2**CW");
  end

  localparam logic [CW-1:0] LAST_K = CW'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  state_e        state_q,  state_d;
  logic [CW-1:0] k_q,      k_d;
  logic [63:0]   tdata_q,  tdata_d;
  logic          tlast_q,  tlast_d;
  logic          tvalid_q, tvalid_d;
  logic          done_q,   done_d;
  logic [CW-1:0] k_next;

  // Each abscissa is computed from k directly rather than by accumulating STEP,
  // so a long frame never drifts by accumulated rounding error.
  function automatic logic [63:0] x_bits(input logic [CW-1:0] k);
    return $realtobits(X0 + real'(k) * STEP);
  endfunction

  assign k_next = k_q + CW'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first. Otherwise a path
    // that leaves a signal unassigned makes synthesis infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SEND;
          k_d      = '0;
          tdata_d  = $realtobits(X0);
          tlast_d  = (NUM_SAMPLES == 1);
          tvalid_d = 1'b1;
        end
      end

      S_SEND: begin
        // TVALID is always 1 in SEND, so TREADY alone marks a handshake.
        // With no handshake, TDATA and TLAST keep their defaults and stay frozen.
        if (nexti.tready) begin
          if (k_q == LAST_K) begin
            state_d  = S_DONE;
            k_d      = '0;
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
            done_d   = 1'b1;
            // tdata_d keeps the last presented value.
          end else begin
            k_d     = k_next;
            tdata_d = x_bits(k_next);
            tlast_d = (k_next == LAST_K);
          end
        end
      end

      S_DONE: begin
        // A start seen here is dropped on purpose and is not queued.
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        k_d      = '0;
        tlast_d  = 1'b0;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then update
  // together, and no flop sees another flop's new value in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
    end
  end

  assign nexto.tvalid = tvalid_q;
  assign nexto.tdata  = tdata_q;
  assign nexto.tlast  = tlast_q;
  assign busy         = tvalid_q;
  assign done         = done_q;
  assign sample_idx   = k_q;

`ifndef SYNTHESIS
  // Simulation-only guard: a downstream stage that holds off for more than 100
  // cycles means the testbench or the system has deadlocked.
  logic [7:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (tvalid_q && !nexti.tready) begin
      if (stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
    end else begin
      stall_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && stall_cnt_q > 8'd100) begin
      $error("horner_x_ramp_source: TVALID stalled by TREADY for more than 100 cycles");
      $finish;
    end
  end
`endif

endmodule
